// File: rtl/window_generator_3x3.sv
// 3x3 neighbourhood builder for a raster pixel stream.
// Emits zero-padded windows and a corner selector per centre pixel.
module window_generator_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] line0_data0,
  output logic [DATA_WIDTH-1:0] line0_data1,
  output logic [DATA_WIDTH-1:0] line0_data2,
  output logic [DATA_WIDTH-1:0] line1_data0,
  output logic [DATA_WIDTH-1:0] line1_data1,
  output logic [DATA_WIDTH-1:0] line1_data2,
  output logic [DATA_WIDTH-1:0] line2_data0,
  output logic [DATA_WIDTH-1:0] line2_data1,
  output logic [DATA_WIDTH-1:0] line2_data2,
  output logic [3:0]            corner_type,
  output logic                  win_valid,
  output logic                  frame_done
);

  localparam int W     = IMG_WIDTH;
  localparam int H     = IMG_HEIGHT;
  localparam int N     = W * H;
  localparam int DEPTH = 2 * W + 3;
  localparam int CW    = $clog2(N + 1);
  localparam int XW    = $clog2(W);
  localparam int YW    = (H > 2) ? $clog2(H) : 1;
  localparam int FW    = $clog2(W + 1);

  localparam logic [CW-1:0] K_RUN  = CW'(W + 1);
  localparam logic [CW-1:0] K_LAST = CW'(N - 1);
  localparam logic [XW-1:0] X_MAX  = XW'(W - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(H - 1);
  localparam logic [FW-1:0] F_MAX  = FW'(W);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt, idx;
  logic [FW-1:0] fl;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;

  logic acc, first, emit, last_pix, last_win;
  logic [2:0] row_ok, col_ok;

  logic [DATA_WIDTH-1:0] sr    [DEPTH];
  logic [DATA_WIDTH-1:0] sr_n  [DEPTH];
  logic [DATA_WIDTH-1:0] tap_n [3][3];
  logic [DATA_WIDTH-1:0] win   [3][3];

  function automatic logic [3:0] corner(
    input logic [XW-1:0] x,
    input logic [YW-1:0] y
  );
    logic xl, xr, yt, yb;
    xl = (x == '0);
    xr = (x == X_MAX);
    yt = (y == '0);
    yb = (y == Y_MAX);
    unique case (1'b1)
      xl & yt:               corner = 4'd1;
      xr & yt:               corner = 4'd2;
      xl & yb:               corner = 4'd5;
      xr & yb:               corner = 4'd6;
      xl & !yt & !yb:        corner = 4'd3;
      xr & !yt & !yb:        corner = 4'd4;
      !xl & !xr & (yt | yb): corner = 4'd7;
      default:               corner = 4'd8;
    endcase
  endfunction

  assign in_ready = (state != FLUSH);

  always_comb begin
    acc      = in_valid & in_ready;
    first    = acc & ((state == IDLE) | in_sof);
    idx      = first ? '0 : cnt;
    emit     = (acc & !first & (idx >= K_RUN))
             | (state == FLUSH);
    last_pix = acc & !first & (idx == K_LAST);
    last_win = (state == FLUSH) & (fl == F_MAX);
    state_nxt = state;
    if (first)
      state_nxt = FILL;
    else if (last_pix)
      state_nxt = FLUSH;
    else if (acc && idx == K_RUN)
      state_nxt = RUN;
    else if (last_win)
      state_nxt = IDLE;
  end

  // newest pixel at sr_n[0] is tap (x+1,y+1); tap (R,C) sits at R*W+C
  always_comb begin
    sr_n[0] = (state == FLUSH) ? '0 : pix_data;
    for (int j = 1; j < DEPTH; j++)
      sr_n[j] = sr[j-1];
    row_ok = {cy != '0, 1'b1, cy != Y_MAX};
    col_ok = {cx != '0, 1'b1, cx != X_MAX};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        tap_n[r][c] = (row_ok[r] & col_ok[c])
                    ? sr_n[r*W+c] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      fl          <= '0;
      cx          <= '0;
      cy          <= '0;
      win_valid   <= 1'b0;
      frame_done  <= 1'b0;
      corner_type <= '0;
      for (int j = 0; j < DEPTH; j++)
        sr[j] <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      state      <= state_nxt;
      win_valid  <= emit;
      frame_done <= last_win;
      corner_type <= emit ? corner(cx, cy) : 4'd0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= emit ? tap_n[r][c] : '0;
      if (acc || state == FLUSH)
        sr <= sr_n;
      if (acc)
        cnt <= idx + 1'b1;
      if (last_pix)
        fl <= '0;
      else if (state == FLUSH)
        fl <= fl + 1'b1;
      if (first) begin
        cx <= '0;
        cy <= '0;
      end else if (emit) begin
        if (cx == X_MAX) begin
          cx <= '0;
          cy <= (cy == Y_MAX) ? '0 : cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
    end
  end

  assign line0_data0 = win[0][0];
  assign line0_data1 = win[0][1];
  assign line0_data2 = win[0][2];
  assign line1_data0 = win[1][0];
  assign line1_data1 = win[1][1];
  assign line1_data2 = win[1][2];
  assign line2_data0 = win[2][0];
  assign line2_data1 = win[2][1];
  assign line2_data2 = win[2][2];

endmodule

// File: tb/tb_window_generator_3x3.sv
// Scoreboard bench for window_generator_3x3 on a 4x3 image.
// Expected windows come from a frame image held by the bench.
module tb_window_generator_3x3;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic in_ready;
  logic [DW-1:0] l00, l01, l02, l10, l11, l12, l20, l21, l22;
  logic [3:0] corner_type;
  logic win_valid, frame_done;

  window_generator_3x3 #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .pix_data   (pix_data),
    .in_ready   (in_ready),
    .line0_data0(l00),
    .line0_data1(l01),
    .line0_data2(l02),
    .line1_data0(l10),
    .line1_data1(l11),
    .line1_data2(l12),
    .line2_data0(l20),
    .line2_data1(l21),
    .line2_data2(l22),
    .corner_type(corner_type),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [71:0] taps;
    logic [3:0]  ct;
    logic        done;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit lat_arm = 0;
  bit rec = 0;
  int nrec = 0;
  int nrdy0 = 0;
  int ndone = 0;
  int m_cnt = 0;
  bit m_busy = 0;
  logic [DW-1:0] img [N];
  logic [71:0] obs_taps [N];
  logic [3:0]  obs_ct   [N];
  logic [3:0]  ct_seq   [N] = '{1, 7, 7, 2, 3, 8, 8, 4, 5, 7, 7, 6};

  task automatic check(input string tag,
                       input logic [71:0] got,
                       input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_ct(input int x, input int y);
    bit l, r, t, b;
    l = (x == 0);
    r = (x == W - 1);
    t = (y == 0);
    b = (y == H - 1);
    if (t && l) return 4'd1;
    if (t && r) return 4'd2;
    if (b && l) return 4'd5;
    if (b && r) return 4'd6;
    if (l) return 4'd3;
    if (r) return 4'd4;
    if (t || b) return 4'd7;
    return 4'd8;
  endfunction

  function automatic logic [71:0] ref_taps(input int c);
    logic [71:0] t;
    int x, y, xx, yy;
    t = '0;
    x = c % W;
    y = c / W;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) begin
        xx = x + 1 - k;
        yy = y + 1 - r;
        if (xx >= 0 && xx < W && yy >= 0 && yy < H)
          t[(8 - (r * 3 + k)) * 8 +: 8] = img[yy * W + xx];
      end
    return t;
  endfunction

  function automatic logic [7:0] tap(input logic [71:0] t,
                                     input int r, input int k);
    return t[(8 - (r * 3 + k)) * 8 +: 8];
  endfunction

  task automatic push(input int c, input bit done);
    exp_t e;
    e.taps = ref_taps(c);
    e.ct   = ref_ct(c % W, c / W);
    e.done = done;
    q.push_back(e);
  endtask

  task automatic model_accept(input logic sof, input logic [DW-1:0] d);
    int idx;
    idx = (!m_busy || sof) ? 0 : m_cnt;
    img[idx] = d;
    m_busy = 1;
    m_cnt = idx + 1;
    if (idx >= W + 1)
      push(idx - W - 1, 0);
    if (idx == N - 1) begin
      for (int c = N - W - 1; c < N; c++)
        push(c, c == N - 1);
      m_busy = 0;
    end
  endtask

  task automatic step(input logic v, input logic s,
                      input logic [DW-1:0] d);
    in_valid = v;
    in_sof   = s;
    pix_data = d;
    if (v && in_ready) begin
      if (lat_arm && acc_cyc < 0) acc_cyc = cyc;
      model_accept(s, d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send(input int from, input int to,
                      input int base, input bit sof0,
                      input bit gaps);
    for (int i = from; i <= to; i++) begin
      step(1'b1, (i == from) && sof0, 8'(base + i));
      if (gaps) step(1'b0, 1'b0, 8'h0);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(tag, 72'(q.size()), 72'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!in_ready) nrdy0++;
      if (frame_done) ndone++;
      if (win_valid) begin
        if (lat_arm) begin
          check("latency", 72'(cyc - acc_cyc + 1), 72'd7);
          lat_arm = 0;
        end
        if (rec && nrec < N) begin
          obs_taps[nrec] = {l00, l01, l02, l10, l11, l12, l20, l21, l22};
          obs_ct[nrec] = corner_type;
          nrec++;
        end
        if (q.size() == 0) begin
          check("spurious_win", 72'd1, 72'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("win_taps",
                {l00, l01, l02, l10, l11, l12, l20, l21, l22},
                e.taps);
          check("corner", 72'(corner_type), 72'(e.ct));
          check("done", 72'(frame_done), 72'(e.done));
        end
      end else begin
        check("idle_done", 72'(frame_done), 72'd0);
        check("idle_ct", 72'(corner_type), 72'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 72'(in_ready), 72'd1);
    check("rst_valid", 72'(win_valid), 72'd0);
    check("rst_done", 72'(frame_done), 72'd0);
    check("rst_ct", 72'(corner_type), 72'd0);
    check("rst_taps", {l00, l01, l02, l10, l11, l12, l20, l21, l22}, 72'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back frame, pixels 1..12
    lat_arm = 1;
    acc_cyc = -1;
    rec = 1;
    nrdy0 = 0;
    ndone = 0;
    send(0, N - 1, 1, 1'b0, 1'b0);
    drain("drain_b2b");
    rec = 0;
    check("nwin_b2b", 72'(nrec), 72'(N));
    check("ndone_b2b", 72'(ndone), 72'd1);
    check("flush_b2b", 72'(nrdy0), 72'd5);
    for (int i = 0; i < N; i++)
      check("ct_seq", 72'(obs_ct[i]), 72'(ct_seq[i]));
    check("c11_l11", 72'(tap(obs_taps[5], 1, 1)), 72'd6);
    check("c11_l00", 72'(tap(obs_taps[5], 0, 0)), 72'd11);
    check("c11_l22", 72'(tap(obs_taps[5], 2, 2)), 72'd1);
    check("c11_l10", 72'(tap(obs_taps[5], 1, 0)), 72'd7);
    check("c11_ct", 72'(obs_ct[5]), 72'd8);
    check("c30_l00", 72'(tap(obs_taps[3], 0, 0)), 72'd0);
    check("c30_l10", 72'(tap(obs_taps[3], 1, 0)), 72'd0);
    check("c30_l2x", 72'(obs_taps[3][23:0]), 72'd0);
    check("c30_l11", 72'(tap(obs_taps[3], 1, 1)), 72'd4);
    check("c30_l02", 72'(tap(obs_taps[3], 0, 2)), 72'd7);
    check("c30_ct", 72'(obs_ct[3]), 72'd2);

    // in_valid toggling 1,0,1,0
    nrdy0 = 0;
    ndone = 0;
    send(0, N - 1, 1, 1'b1, 1'b1);
    drain("drain_gap");
    check("ndone_gap", 72'(ndone), 72'd1);
    check("flush_gap", 72'(nrdy0), 72'd5);

    // sof on pixel 6 restarts the frame there
    ndone = 0;
    send(0, 4, 1, 1'b1, 1'b0);
    send(5, 5 + N - 1, 1, 1'b1, 1'b0);
    drain("drain_sof");
    check("ndone_sof", 72'(ndone), 72'd1);

    // reset while flushing
    send(0, N - 1, 40, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 72'(win_valid), 72'd0);
    check("arst_ct", 72'(corner_type), 72'd0);
    check("arst_taps", {l00, l01, l02, l10, l11, l12, l20, l21, l22}, 72'd0);
    q.delete();
    m_busy = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_ready", 72'(in_ready), 72'd1);
    ndone = 0;
    nrdy0 = 0;
    send(0, N - 1, 100, 1'b0, 1'b0);
    drain("drain_rst");
    check("ndone_rst", 72'(ndone), 72'd1);
    check("flush_rst", 72'(nrdy0), 72'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
